// File: rtl/alu_cmd_sender_pkg.sv
// Shared definitions for the ALU command link: frame marker bytes and FSM state encoding.
// The receive-side interface circuit imports the same package so both ends agree on markers.
package alu_cmd_sender_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    WAIT_TX     = 2'd2,
    WAIT_RESULT = 2'd3
  } state_t;

  localparam logic [7:0] DATA     = 8'h64;
  localparam logic [7:0] OP       = 8'h6F;
  localparam logic [2:0] LAST_IDX = 3'd5;

endpackage

// File: rtl/alu_cmd_sender_timeout_counter.sv
// Result-wait timer: counts enabled cycles after a clear; o_expired flags the last allowed cycle.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_expired;

  // The first enabled cycle sees count 0, so the TIMEOUT_CYCLES-th one sees LAST.
  assign w_expired = (r_count == LAST);
  assign o_expired = w_expired;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_sender.sv
// Sends a six-byte ALU command frame over a UART transmitter and waits for the one-byte result,
// giving up after TIMEOUT_CYCLES cycles.
module alu_cmd_sender
  import alu_cmd_sender_pkg::*;
#(
  parameter int DBIT           = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [DBIT-1:0]  i_data_one,
  input  logic [DBIT-1:0]  i_data_two,
  input  logic [NB_OP-1:0] i_operation,
  output logic             o_busy,
  output logic [DBIT-1:0]  o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_done,
  input  logic             i_rx_done,
  input  logic [DBIT-1:0]  i_rx_data,
  output logic [DBIT-1:0]  o_result,
  output logic             o_result_valid,
  output logic             o_timeout
);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_next;
  logic [DBIT-1:0]  r_op1;
  logic [DBIT-1:0]  r_op2;
  logic [NB_OP-1:0] r_opc;
  logic [DBIT-1:0]  r_result;
  logic             r_result_valid;
  logic             w_latch;
  logic             w_clear;
  logic             w_rx_take;
  logic             w_expired;
  logic             w_tx_start;
  logic             w_busy;
  logic             w_timeout;
  logic [DBIT-1:0]  w_frame_byte;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_clear),
    .i_enable (r_state == WAIT_RESULT),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_op1          <= '0;
      r_op2          <= '0;
      r_opc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_idx          <= w_idx_next;
      r_result_valid <= w_rx_take;
      if (w_latch) begin
        r_op1 <= i_data_one;
        r_op2 <= i_data_two;
        r_opc <= i_operation;
      end
      if (w_rx_take) begin
        r_result <= i_rx_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_latch      = 1'b0;
    w_clear      = 1'b0;
    w_rx_take    = 1'b0;
    w_tx_start   = 1'b0;
    w_busy       = 1'b1;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_latch      = 1'b1;
          w_idx_next   = '0;
          w_state_next = SEND;
        end
      end
      SEND: begin
        w_tx_start   = 1'b1;
        w_state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          if (r_idx == LAST_IDX) begin
            w_clear      = 1'b1;
            w_state_next = WAIT_RESULT;
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_state_next = SEND;
          end
        end
      end
      WAIT_RESULT: begin
        // A result arriving in the final wait cycle wins over the timeout.
        if (i_rx_done) begin
          w_rx_take    = 1'b1;
          w_state_next = IDLE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_frame_byte = '0;
    case (r_idx)
      3'd0:    w_frame_byte = DBIT'(DATA);
      3'd1:    w_frame_byte = r_op1;
      3'd2:    w_frame_byte = DBIT'(DATA);
      3'd3:    w_frame_byte = r_op2;
      3'd4:    w_frame_byte = DBIT'(OP);
      default: w_frame_byte = DBIT'(r_opc);
    endcase
  end

  // The index only moves on the edge after i_tx_done, so the byte holds through the whole handshake.
  assign o_tx_data      = (r_state == SEND || r_state == WAIT_TX) ? w_frame_byte : '0;
  assign o_tx_start     = w_tx_start;
  assign o_busy         = w_busy;
  assign o_timeout      = w_timeout;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;

endmodule

// File: doc/alu_cmd_sender.md
ALU_CMD_SENDER -- requirements
Module: alu_cmd_sender

Interface
REQ-001 Parameter DBIT, default 8, sets the UART byte width and operand width.
REQ-002 Parameter NB_OP, default 6, sets the operation code width (NB_OP <= DBIT).
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000, sets the result-wait limit in i_clk cycles (>= 2).
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  request pulse that starts one command transaction.
REQ-007 i_data_one  in  DBIT  first operand.
REQ-008 i_data_two  in  DBIT  second operand.
REQ-009 i_operation  in  NB_OP  ALU operation code.
REQ-010 o_busy  out  1  high while a transaction is in progress.
REQ-011 o_tx_data  out  DBIT  byte presented to the UART transmitter.
REQ-012 o_tx_start  out  1  one-cycle pulse that launches o_tx_data.
REQ-013 i_tx_done  in  1  one-cycle pulse when the UART transmitter finishes a byte.
REQ-014 i_rx_done  in  1  one-cycle pulse when the UART receiver holds a byte.
REQ-015 i_rx_data  in  DBIT  received byte (ALU result).
REQ-016 o_result  out  DBIT  last received ALU result, held until the next one arrives.
REQ-017 o_result_valid  out  1  one-cycle pulse when o_result updates.
REQ-018 o_timeout  out  1  one-cycle pulse when the result wait expires.

Function
REQ-019 FSM states SHALL be IDLE, SEND, WAIT_TX, WAIT_RESULT.
REQ-020 In IDLE, i_start=1 SHALL latch i_data_one, i_data_two and i_operation, clear the 3-bit byte index, and go to SEND.
REQ-021 Frame order SHALL be: index 0 = 8'h64, 1 = operand one, 2 = 8'h64, 3 = operand two, 4 = 8'h6F, 5 = operation zero-extended to DBIT.
REQ-022 SEND SHALL assert o_tx_start for exactly one cycle with o_tx_data = byte[index], then go to WAIT_TX.
REQ-023 o_tx_data SHALL remain stable from the o_tx_start cycle until the matching i_tx_done.
REQ-024 In WAIT_TX, i_tx_done with index < 5 SHALL increment the index and go to SEND; with index = 5 it SHALL clear the timeout counter and go to WAIT_RESULT.
REQ-025 Latency: i_start in cycle N SHALL give the first o_tx_start in cycle N+1; i_tx_done in cycle M SHALL give the next o_tx_start in cycle M+1.
REQ-026 In WAIT_RESULT, i_rx_done SHALL load o_result from i_rx_data, pulse o_result_valid in the following cycle, and return to IDLE.
REQ-027 In WAIT_RESULT, after TIMEOUT_CYCLES cycles without i_rx_done, the block SHALL pulse o_timeout, leave o_result unchanged, and return to IDLE.
REQ-028 i_rx_done and the timeout expiring in the same cycle SHALL count as a result; o_timeout stays low.
REQ-029 i_start outside IDLE SHALL be ignored; latched operands SHALL not change mid-transaction.
REQ-030 i_tx_done outside WAIT_TX and i_rx_done outside WAIT_RESULT SHALL be ignored.
REQ-031 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 While i_reset=1 (asynchronous assertion), state = IDLE, index = 0, timeout counter = 0, latched operands = 0.
REQ-033 During reset, o_result = 0 and o_tx_data = 0, and o_tx_start, o_result_valid, o_timeout and o_busy are all 0.
REQ-034 Reset in the middle of a frame SHALL abort it with no further o_tx_start; reset SHALL take priority over i_start.

Structure
REQ-035 Marker constants DATA = 8'h64 and OP = 8'h6F SHALL be kept in a shared package also used by the receive-side interface circuit, along with the state encodings.
REQ-036 The timeout counter SHALL be a separate sub-module, timeout_counter, with clear, enable and expired ports.

Verification
REQ-037 Basic transaction: reset, then i_start with operands 8'h05/8'h03 and op 6'h20, with the tx model giving i_tx_done 10 cycles after each start.
  -> bytes 64,05,64,03,6F,20 in that order, each with a one-cycle o_tx_start.
  -> then i_rx_data = 8'h08 -> o_result = 8'h08, one o_result_valid pulse, o_busy low.
REQ-038 Second i_start during WAIT_TX of byte 2 -> ignored; the frame completes with the original operands.
REQ-039 No i_rx_done, with TIMEOUT_CYCLES = 16 -> o_timeout pulses 16 cycles after the last i_tx_done; o_result keeps its previous value.
REQ-040 i_reset asserted asynchronously mid-frame after byte 3 -> all outputs 0 at once; a new i_start then sends a fresh frame beginning with 8'h64.
REQ-041 Stray i_rx_done during SEND/WAIT_TX, and i_tx_done in IDLE -> no state change and no o_result update; i_rx_done in the timeout cycle -> o_result_valid=1, o_timeout=0.
